// File: rtl/turfio_bank_init_seq.sv
// Bring-up sequencer for the TURFIO MMCM, IDELAYCTRL and IDELAY/ISERDES resets
// in banks 67 and 68, with timeout retries and lock-loss monitoring once up.
module turfio_bank_init_seq #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned RDY_TIMEOUT  = 4096,
  parameter int unsigned MAX_RETRY    = 3,
  parameter bit          AUTO_RESTART = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic [1:0] bank_mask_i,
  input  logic [1:0] mmcm_locked_i,
  input  logic [1:0] idelayctrl_rdy_i,
  output logic [1:0] mmcm_rst_o,
  output logic [1:0] idelayctrl_rst_o,
  output logic [1:0] bank_rst_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       fail_o,
  output logic [1:0] fail_code_o,
  output logic [3:0] retry_cnt_o,
  output logic       lock_lost_o
);

  localparam int unsigned TMO_MAX = (LOCK_TIMEOUT > RDY_TIMEOUT) ? LOCK_TIMEOUT : RDY_TIMEOUT;
  localparam int unsigned CNT_MAX = (TMO_MAX > RST_CYCLES) ? TMO_MAX : RST_CYCLES;
  localparam int          CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] RDY_LAST  = CW'(RDY_TIMEOUT - 1);
  localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRY);

  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_LOCK = 2'd1;
  localparam logic [1:0] CODE_RDY  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MMCM_RST,
    S_WAIT_LOCK,
    S_IDC_RST,
    S_WAIT_RDY,
    S_BANK_REL,
    S_DONE,
    S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mask_q, mask_d;
  logic [3:0]    retry_q, retry_d;
  logic [1:0]    fail_code_q, fail_code_d;
  logic          lock_lost_q, lock_lost_d;

  // Two-flop synchronisers for the asynchronous status inputs.
  logic [1:0] lock_s1_q, lock_s2_q;
  logic [1:0] rdy_s1_q, rdy_s2_q;

  logic [1:0] mmcm_rst_q, mmcm_rst_d;
  logic [1:0] idc_rst_q, idc_rst_d;
  logic [1:0] bank_rst_q, bank_rst_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       fail_q, fail_d;
  logic [1:0] code_out_q, code_out_d;
  logic [3:0] retry_out_q, retry_out_d;
  logic       lost_out_q, lost_out_d;

  logic       start_ok;
  logic       locked_all;
  logic       rdy_all;
  logic       timed_state;
  logic       to_req;
  logic [1:0] to_code;

  assign start_ok    = start_i && (bank_mask_i != 2'b00);
  assign locked_all  = ((lock_s2_q & mask_q) == mask_q);
  assign rdy_all     = ((rdy_s2_q & mask_q) == mask_q);
  assign timed_state = (state_q inside {S_MMCM_RST, S_WAIT_LOCK, S_IDC_RST, S_WAIT_RDY, S_BANK_REL});

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    retry_d     = retry_q;
    fail_code_d = fail_code_q;
    lock_lost_d = lock_lost_q;
    to_req      = 1'b0;
    to_code     = CODE_NONE;

    case (state_q)
      S_IDLE, S_FAIL: begin
        if (start_ok) state_d = S_MMCM_RST;
      end
      S_MMCM_RST: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_all) begin
          state_d = S_IDC_RST;
        end else if (cnt_q == LOCK_LAST) begin
          to_req  = 1'b1;
          to_code = CODE_LOCK;
        end
      end
      S_IDC_RST: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        // A lock dropping while waiting for ready invalidates the attempt.
        if (!locked_all) begin
          to_req  = 1'b1;
          to_code = CODE_LOCK;
        end else if (rdy_all) begin
          state_d = S_BANK_REL;
        end else if (cnt_q == RDY_LAST) begin
          to_req  = 1'b1;
          to_code = CODE_RDY;
        end
      end
      S_BANK_REL: begin
        if (cnt_q == RST_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        if (start_ok) begin
          state_d = S_MMCM_RST;
        end else if (!locked_all) begin
          lock_lost_d = 1'b1;
          if (AUTO_RESTART) begin
            state_d = S_MMCM_RST;
            retry_d = 4'd0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_ok && (state_q inside {S_IDLE, S_DONE, S_FAIL})) begin
      mask_d      = bank_mask_i;
      retry_d     = 4'd0;
      fail_code_d = CODE_NONE;
      lock_lost_d = 1'b0;
    end

    if (to_req) begin
      if (retry_q < RETRY_LIM) begin
        retry_d = retry_q + 4'd1;
        state_d = S_MMCM_RST;
      end else begin
        state_d     = S_FAIL;
        fail_code_d = to_code;
      end
    end

    if ((state_d != state_q) || !timed_state) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs are a registered image of the current state, one cycle behind it.
  always_comb begin
    busy_d      = timed_state;
    done_d      = (state_q == S_DONE);
    fail_d      = (state_q == S_FAIL);
    mmcm_rst_d  = (state_q == S_MMCM_RST) ? mask_q : 2'b00;
    idc_rst_d   = (state_q inside {S_MMCM_RST, S_WAIT_LOCK, S_IDC_RST}) ? mask_q : 2'b00;
    bank_rst_d  = timed_state ? mask_q : 2'b00;
    code_out_d  = fail_code_q;
    retry_out_d = retry_q;
    lost_out_d  = lock_lost_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mask_q      <= 2'b00;
      retry_q     <= 4'd0;
      fail_code_q <= CODE_NONE;
      lock_lost_q <= 1'b0;
      lock_s1_q   <= 2'b00;
      lock_s2_q   <= 2'b00;
      rdy_s1_q    <= 2'b00;
      rdy_s2_q    <= 2'b00;
      mmcm_rst_q  <= 2'b00;
      idc_rst_q   <= 2'b00;
      bank_rst_q  <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      code_out_q  <= 2'b00;
      retry_out_q <= 4'd0;
      lost_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      retry_q     <= retry_d;
      fail_code_q <= fail_code_d;
      lock_lost_q <= lock_lost_d;
      lock_s1_q   <= mmcm_locked_i;
      lock_s2_q   <= lock_s1_q;
      rdy_s1_q    <= idelayctrl_rdy_i;
      rdy_s2_q    <= rdy_s1_q;
      mmcm_rst_q  <= mmcm_rst_d;
      idc_rst_q   <= idc_rst_d;
      bank_rst_q  <= bank_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      code_out_q  <= code_out_d;
      retry_out_q <= retry_out_d;
      lost_out_q  <= lost_out_d;
    end
  end

  assign mmcm_rst_o       = mmcm_rst_q;
  assign idelayctrl_rst_o = idc_rst_q;
  assign bank_rst_o       = bank_rst_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign fail_o           = fail_q;
  assign fail_code_o      = code_out_q;
  assign retry_cnt_o      = retry_out_q;
  assign lock_lost_o      = lost_out_q;

endmodule
